// File: rtl/gpio_pad_pkg.sv
// Shared types and helpers for the GPIO pad controller: pad drive modes,
// direction constants and the per-channel debounce threshold type.
package gpio_pad_pkg;

  localparam logic        GPIO_DIR_IN   = 1'b0;
  localparam logic        GPIO_DIR_OUT  = 1'b1;
  localparam int unsigned GPIO_SYNC_MIN = 2;
  localparam int unsigned GPIO_DB_WIDTH = 8;

  typedef logic [GPIO_DB_WIDTH-1:0] gpio_db_thresh_t;

  typedef enum logic [1:0] {
    PAD_MODE_IN,
    PAD_MODE_PUSH_PULL,
    PAD_MODE_OPEN_DRAIN
  } pad_mode_e;

  typedef struct packed {
    logic out;
    logic oen;
    logic ren;
  } pad_drive_t;

  // Released pad with pull enabled: the safe state for an input or a reset pad.
  localparam pad_drive_t PAD_DRIVE_IDLE = '{out: 1'b0, oen: 1'b1, ren: 1'b1};

  function automatic pad_mode_e pad_mode(input logic dir, input logic od);
    if (dir == GPIO_DIR_IN) begin
      pad_mode = PAD_MODE_IN;
    end else if (od) begin
      pad_mode = PAD_MODE_OPEN_DRAIN;
    end else begin
      pad_mode = PAD_MODE_PUSH_PULL;
    end
  endfunction

  function automatic pad_drive_t pad_drive(input pad_mode_e mode, input logic data);
    pad_drive = PAD_DRIVE_IDLE;
    case (mode)
      PAD_MODE_PUSH_PULL: begin
        pad_drive.out = data;
        pad_drive.oen = 1'b0;
        pad_drive.ren = 1'b0;
      end
      // Open-drain only ever pulls low; a 1 releases the pad to the pull-up.
      PAD_MODE_OPEN_DRAIN: begin
        pad_drive.out = 1'b0;
        pad_drive.oen = data;
        pad_drive.ren = 1'b1;
      end
      default: pad_drive = PAD_DRIVE_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/gpio_debounce.sv
// Single-channel pad input path: synchroniser chain, threshold debounce and
// rise/fall pulse generation from the debounced value.
module gpio_debounce
  import gpio_pad_pkg::*;
#(
  parameter int unsigned SYNC_STAGE = GPIO_SYNC_MIN,
  parameter int unsigned DB_WIDTH   = GPIO_DB_WIDTH
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                pad_in_i,
  input  logic [DB_WIDTH-1:0] thresh_i,
  output logic                in_o,
  output logic                rise_o,
  output logic                fall_o
);

  localparam int unsigned SYNC_N = (SYNC_STAGE < GPIO_SYNC_MIN) ? GPIO_SYNC_MIN : SYNC_STAGE;

  logic [SYNC_N-1:0]   sync_q;
  logic                sync;
  logic [DB_WIDTH-1:0] cnt_q;
  logic [DB_WIDTH-1:0] cnt_d;
  logic                stable_q;
  logic                stable_d;
  logic                stable_dly_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_N-2:0], pad_in_i};
    end
  end

  assign sync = sync_q[SYNC_N-1];

  // cnt+1 >= thresh is evaluated as cnt >= thresh-1 (thresh is nonzero here),
  // which avoids a wider adder and still accepts at once after a threshold drop.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (thresh_i == '0) begin
      stable_d = sync;
    end else if (sync != stable_q) begin
      if (cnt_q >= thresh_i - DB_WIDTH'(1)) begin
        stable_d = sync;
      end else begin
        cnt_d = cnt_q + DB_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q        <= '0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
    end
  end

  assign in_o   = stable_q;
  assign rise_o = stable_q & ~stable_dly_q;
  assign fall_o = ~stable_q & stable_dly_q;

endmodule

// File: rtl/gpio_pad_ctrl.sv
// Multi-channel GPIO pad controller: registered pad drive (push-pull or
// open-drain) and per-channel debounced input with edge pulses.
module gpio_pad_ctrl
  import gpio_pad_pkg::*;
#(
  parameter int unsigned CHANNEL_NUM = 8,
  parameter int unsigned SYNC_STAGE  = 2,
  parameter int unsigned DB_WIDTH    = $bits(gpio_db_thresh_t)
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [CHANNEL_NUM-1:0]          dir_i,
  input  logic [CHANNEL_NUM-1:0]          od_i,
  input  logic [CHANNEL_NUM-1:0]          out_i,
  input  logic [DB_WIDTH*CHANNEL_NUM-1:0] db_thresh_i,
  output logic [CHANNEL_NUM-1:0]          in_o,
  output logic [CHANNEL_NUM-1:0]          rise_o,
  output logic [CHANNEL_NUM-1:0]          fall_o,
  output logic [CHANNEL_NUM-1:0]          pad_out_o,
  output logic [CHANNEL_NUM-1:0]          pad_oen_o,
  output logic [CHANNEL_NUM-1:0]          pad_ren_o,
  input  logic [CHANNEL_NUM-1:0]          pad_in_i
);

  pad_drive_t drive_d [CHANNEL_NUM];

  always_comb begin
    for (int unsigned i = 0; i < CHANNEL_NUM; i++) begin
      drive_d[i] = pad_drive(pad_mode(dir_i[i], od_i[i]), out_i[i]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pad_out_o <= '0;
      pad_oen_o <= '1;
      pad_ren_o <= '1;
    end else begin
      for (int unsigned i = 0; i < CHANNEL_NUM; i++) begin
        pad_out_o[i] <= drive_d[i].out;
        pad_oen_o[i] <= drive_d[i].oen;
        pad_ren_o[i] <= drive_d[i].ren;
      end
    end
  end

  // The input path ignores dir_i so output channels read back their own pad.
  for (genvar ch = 0; ch < CHANNEL_NUM; ch++) begin : g_chan
    gpio_debounce #(
      .SYNC_STAGE (SYNC_STAGE),
      .DB_WIDTH   (DB_WIDTH)
    ) u_debounce (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .pad_in_i (pad_in_i[ch]),
      .thresh_i (db_thresh_i[ch*DB_WIDTH +: DB_WIDTH]),
      .in_o     (in_o[ch]),
      .rise_o   (rise_o[ch]),
      .fall_o   (fall_o[ch])
    );
  end

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Bench for gpio_pad_ctrl: window-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_gpio_pad_ctrl;

  localparam int CH = 8;
  localparam int S  = 2;
  localparam int W  = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [CH-1:0]   dir, od, out, pad_in;
  logic [CH*W-1:0] thresh;
  logic [CH-1:0]   in_o, rise_o, fall_o, pad_out, pad_oen, pad_ren;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gpio_pad_ctrl #(
    .CHANNEL_NUM (CH),
    .SYNC_STAGE  (S),
    .DB_WIDTH    (W)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .dir_i       (dir),
    .od_i        (od),
    .out_i       (out),
    .db_thresh_i (thresh),
    .in_o        (in_o),
    .rise_o      (rise_o),
    .fall_o      (fall_o),
    .pad_out_o   (pad_out),
    .pad_oen_o   (pad_oen),
    .pad_ren_o   (pad_ren),
    .pad_in_i    (pad_in)
  );

  // Reference model: pad history per channel (bit 0 = newest sample). The
  // debounced value flips once the last T synchronised samples all differ from it.
  logic [63:0]   m_sh [CH];
  logic [CH-1:0] m_in, m_inq, m_out, m_oen, m_ren;
  bit            chk_en = 0;
  int            rise_cnt [CH];
  int            fall_cnt [CH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    for (int c = 0; c < CH; c++) begin
      if (rst) begin
        m_sh[c]  = '0;
        m_in[c]  = 1'b0;
        m_inq[c] = 1'b0;
        m_out[c] = 1'b0;
        m_oen[c] = 1'b1;
        m_ren[c] = 1'b1;
      end else begin
        int t;
        bit all_diff;
        t = int'(thresh[c*W +: W]);
        m_inq[c] = m_in[c];
        if (t == 0) begin
          m_in[c] = m_sh[c][S-1];
        end else begin
          all_diff = 1;
          for (int j = 1; j <= t; j++)
            if (m_sh[c][S-2+j] == m_in[c]) all_diff = 0;
          if (all_diff) m_in[c] = ~m_in[c];
        end
        m_sh[c] = {m_sh[c][62:0], pad_in[c]};
        if (!dir[c]) begin
          m_out[c] = 1'b0; m_oen[c] = 1'b1; m_ren[c] = 1'b1;
        end else if (od[c]) begin
          m_out[c] = 1'b0; m_oen[c] = out[c]; m_ren[c] = 1'b1;
        end else begin
          m_out[c] = out[c]; m_oen[c] = 1'b0; m_ren[c] = 1'b0;
        end
      end
    end
    chk_en = 1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_o",    32'(in_o),    32'(m_in));
      check("rise_o",  32'(rise_o),  32'(m_in & ~m_inq));
      check("fall_o",  32'(fall_o),  32'(~m_in & m_inq));
      check("pad_out", 32'(pad_out), 32'(m_out));
      check("pad_oen", 32'(pad_oen), 32'(m_oen));
      check("pad_ren", 32'(pad_ren), 32'(m_ren));
      for (int c = 0; c < CH; c++) begin
        rise_cnt[c] += int'(rise_o[c]);
        fall_cnt[c] += int'(fall_o[c]);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic clear_counts();
    for (int c = 0; c < CH; c++) begin
      rise_cnt[c] = 0;
      fall_cnt[c] = 0;
    end
  endtask

  task automatic set_thresh(input int c, input int v);
    thresh[c*W +: W] = W'(v);
  endtask

  initial begin
    rst    = 1'b1;
    dir    = CH'($urandom);
    od     = CH'($urandom);
    out    = CH'($urandom);
    pad_in = CH'($urandom);
    thresh = {$urandom, $urandom};
    repeat (3) begin
      tick(1);
      dir    = CH'($urandom);
      od     = CH'($urandom);
      out    = CH'($urandom);
      pad_in = CH'($urandom);
    end
    check("rst pad_oen", 32'(pad_oen), 32'hFF);
    check("rst pad_out", 32'(pad_out), 32'h00);
    check("rst pad_ren", 32'(pad_ren), 32'hFF);
    check("rst in_o",    32'(in_o),    32'h00);
    check("rst edges",   32'(rise_o | fall_o), 32'h00);

    rst = 1'b0; dir = '0; od = '0; out = '0; pad_in = '0;
    thresh = '0;
    set_thresh(0, 4); set_thresh(1, 4); set_thresh(2, 0); set_thresh(3, 5);
    set_thresh(4, 5); set_thresh(5, 3); set_thresh(6, 1); set_thresh(7, 2);
    tick(4);

    // Push-pull on ch0
    dir = 8'h01; od = 8'h00; out = 8'h01;
    tick(1);
    check("pp oen0", 32'(pad_oen[0]), 0);
    check("pp out0", 32'(pad_out[0]), 1);
    check("pp ren0", 32'(pad_ren[0]), 0);
    out = 8'h00;
    tick(1);
    check("pp out0 low", 32'(pad_out[0]), 0);

    // Open-drain on ch1
    dir = 8'h02; od = 8'h02; out = 8'h00;
    tick(1);
    check("od out1", 32'(pad_out[1]), 0);
    check("od oen1 drive", 32'(pad_oen[1]), 0);
    check("od ren1", 32'(pad_ren[1]), 1);
    out = 8'h02;
    tick(1);
    check("od oen1 release", 32'(pad_oen[1]), 1);
    check("od out1 stays", 32'(pad_out[1]), 0);

    // Debounce accept ch0, T=4: change visible after 2+4 edges
    clear_counts();
    pad_in[0] = 1'b1;
    tick(5);
    check("db0 before", 32'(in_o[0]), 0);
    tick(1);
    check("db0 accept", 32'(in_o[0]), 1);
    check("db0 rise", 32'(rise_o[0]), 1);
    tick(1);
    check("db0 rise one cycle", 32'(rise_o[0]), 0);
    pad_in[0] = 1'b0;
    tick(5);
    check("db0 hold high", 32'(in_o[0]), 1);
    tick(1);
    check("db0 fall", 32'(fall_o[0]), 1);
    check("db0 low", 32'(in_o[0]), 0);
    tick(1);
    check("db0 rise count", 32'(rise_cnt[0]), 1);
    check("db0 fall count", 32'(fall_cnt[0]), 1);

    // Glitch reject then accept on ch1, T=4
    clear_counts();
    pad_in[1] = 1'b1; tick(3); pad_in[1] = 1'b0; tick(10);
    check("glitch in1", 32'(in_o[1]), 0);
    check("glitch rise1", 32'(rise_cnt[1]), 0);
    pad_in[1] = 1'b1; tick(4); pad_in[1] = 1'b0; tick(10);
    check("held4 rise1", 32'(rise_cnt[1]), 1);
    check("held4 fall1", 32'(fall_cnt[1]), 1);

    // Bypass ch2 vs ch3 with T=5, one-cycle pulse
    clear_counts();
    pad_in[2] = 1'b1; pad_in[3] = 1'b1;
    tick(1);
    pad_in[2] = 1'b0; pad_in[3] = 1'b0;
    tick(1);
    check("byp2 before", 32'(in_o[2]), 0);
    tick(1);
    check("byp2 high", 32'(in_o[2]), 1);
    check("byp2 rise", 32'(rise_o[2]), 1);
    tick(1);
    check("byp2 low", 32'(in_o[2]), 0);
    check("byp2 fall", 32'(fall_o[2]), 1);
    tick(6);
    check("byp2 rise count", 32'(rise_cnt[2]), 1);
    check("byp2 fall count", 32'(fall_cnt[2]), 1);
    check("ch3 untouched", 32'(rise_cnt[3] + fall_cnt[3]), 0);
    check("ch3 in", 32'(in_o[3]), 0);

    // Threshold drop mid-count on ch4 accepts immediately
    pad_in[4] = 1'b1;
    tick(5);
    check("thr4 counting", 32'(in_o[4]), 0);
    set_thresh(4, 2);
    tick(1);
    check("thr4 accept", 32'(in_o[4]), 1);
    check("thr4 rise", 32'(rise_o[4]), 1);

    // Reset mid-debounce on ch5, then post-reset rise after 2+3 edges
    clear_counts();
    pad_in[5] = 1'b1;
    tick(3);
    rst = 1'b1;
    tick(1);
    check("midrst in", 32'(in_o), 0);
    check("midrst edges", 32'(rise_o | fall_o), 0);
    check("midrst oen", 32'(pad_oen), 32'hFF);
    rst = 1'b0;
    tick(4);
    check("postrst in5 before", 32'(in_o[5]), 0);
    tick(1);
    check("postrst in5", 32'(in_o[5]), 1);
    check("postrst rise5", 32'(rise_o[5]), 1);
    check("postrst fall count", 32'(fall_cnt[5]), 0);

    // Random traffic, checked cycle by cycle against the model
    for (int n = 0; n < 400; n++) begin
      dir = CH'($urandom);
      od  = CH'($urandom);
      out = CH'($urandom);
      pad_in = pad_in ^ CH'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 15) == 0) set_thresh($urandom_range(0, CH-1), $urandom_range(0, 6));
      rst = ($urandom_range(0, 79) == 0);
      tick(1);
    end
    rst = 1'b0;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
